// File: rtl/compressor_pkg.sv
// Shared constants and types for the compressor input-side arbitration slice.
package compressor_pkg;
  localparam int DATA_W          = 256;
  localparam int NUM_REQ_DEFAULT = 4;
  localparam int ID_W            = $clog2(NUM_REQ_DEFAULT);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_t;
endpackage

// File: rtl/id_fifo.sv
// Small synchronous FIFO of requester IDs; push is refused when full, pop when empty.
module id_fifo
  import compressor_pkg::*;
#(
  parameter int WIDTH = ID_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the pre-pop count, so push+pop at full only pops.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/compressor_input_arbiter.sv
// Packet-granular round-robin arbiter feeding the compressor input FIFO under credit
// flow control; granted IDs are queued in order for routing results back.
module compressor_input_arbiter
  import compressor_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEFAULT,
  parameter int DATA_W   = compressor_pkg::DATA_W,
  parameter int CREDITS  = 8,
  parameter int ID_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           cmp_data,
  output logic                        cmp_push,
  input  logic                        cmp_credit,
  input  logic                        cmp_done,
  output logic [$clog2(NUM_REQ)-1:0]  done_id,
  output logic                        done_id_valid,
  output logic                        busy,
  output logic                        err
);
  localparam int          IW   = $clog2(NUM_REQ);
  localparam int          CW   = $clog2(CREDITS + 1);
  localparam int unsigned NR_U = NUM_REQ;

  arb_state_t    state;
  logic [IW-1:0] grant;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] next_grant;
  logic [CW-1:0] credits;
  logic          credit_avail;
  logic          credit_in;
  logic          accept;
  logic          id_push;
  logic          id_full;
  logic          id_empty;

  // First valid requester strictly after 'last', wrapping around.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [IW-1:0]      last);
    logic [IW-1:0] win;
    logic          found;
    int unsigned   idx;
    win   = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NR_U; i++) begin
      idx = (32'(last) + i) % NR_U;
      if (!found && valid[IW'(idx)]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign next_grant   = rr_pick(req_valid, last_grant);
  assign credit_avail = (credits != '0);
  assign credit_in    = cmp_credit && (credits != CW'(CREDITS));
  assign accept       = (state == STREAM) && req_valid[grant] && credit_avail;
  assign id_push      = (state == IDLE) && (|req_valid) && !id_full;

  always_comb begin
    req_ready = '0;
    if (state == STREAM && credit_avail) req_ready[grant] = 1'b1;
  end

  assign done_id_valid = !id_empty;
  assign busy          = (state == STREAM) || !id_empty;

  id_fifo #(
    .WIDTH(IW),
    .DEPTH(ID_DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (id_push),
    .din   (next_grant),
    .pop   (cmp_done),
    .dout  (done_id),
    .full  (id_full),
    .empty (id_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      credits    <= CW'(CREDITS);
      cmp_data   <= '0;
      cmp_push   <= 1'b0;
      err        <= 1'b0;
    end else begin
      cmp_push <= accept;
      if (accept) cmp_data <= req_data[grant*DATA_W +: DATA_W];

      case (state)
        IDLE: begin
          if (id_push) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (accept && req_last[grant]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      case ({credit_in, accept})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: ;
      endcase

      if ((cmp_credit && !credit_in) || (cmp_done && id_empty)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_compressor_input_arbiter.sv
// Bench for compressor_input_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_compressor_input_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 256;
  localparam int CR  = 8;
  localparam int IDD = 4;
  localparam int IW  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    cmp_data;
  logic             cmp_push;
  logic             cmp_credit;
  logic             cmp_done;
  logic [IW-1:0]    done_id;
  logic             done_id_valid;
  logic             busy;
  logic             err;

  always #5 clk = ~clk;

  compressor_input_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .CREDITS (CR),
    .ID_DEPTH(IDD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .cmp_data     (cmp_data),
    .cmp_push     (cmp_push),
    .cmp_credit   (cmp_credit),
    .cmp_done     (cmp_done),
    .done_id      (done_id),
    .done_id_valid(done_id_valid),
    .busy         (busy),
    .err          (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: packet-in-progress flag, owner, credit count, ID queue.
  bit            m_in_pkt  = 1'b0;
  int            m_owner   = 0;
  int            m_last    = NR - 1;
  int            m_credits = CR;
  int            m_q[$];
  bit            m_push    = 1'b0;
  logic [DW-1:0] m_data    = '0;
  bit            m_err     = 1'b0;
  int            m_acc     = -1;
  int            grant_log[$];
  int            push_cycles[$];
  int            cyc_n     = 0;

  function automatic int rr_winner(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit acc;
    bit grant_now;
    int w;
    if (reset) begin
      m_in_pkt = 0; m_owner = 0; m_last = NR - 1; m_credits = CR;
      m_q.delete(); m_push = 0; m_data = '0; m_err = 0; m_acc = -1;
      return;
    end
    acc       = m_in_pkt && (m_credits > 0) && req_valid[m_owner];
    m_acc     = acc ? m_owner : -1;
    grant_now = !m_in_pkt && (req_valid != '0) && (m_q.size() < IDD);
    w         = rr_winner(req_valid, m_last);
    m_push    = acc;
    if (acc) m_data = req_data[m_owner*DW +: DW];
    if (cmp_credit) begin
      if (m_credits == CR) m_err = 1;
      else m_credits++;
    end
    if (acc) m_credits--;
    if (cmp_done) begin
      if (m_q.size() == 0) m_err = 1;
      else void'(m_q.pop_front());
    end
    if (grant_now) begin
      m_q.push_back(w);
      grant_log.push_back(w);
      m_in_pkt = 1; m_owner = w; m_last = w;
    end else if (acc && req_last[m_owner]) begin
      m_in_pkt = 0;
    end
  endtask

  task automatic compare();
    logic [NR-1:0] exp_ready;
    exp_ready = '0;
    if (m_in_pkt && m_credits > 0) exp_ready[m_owner] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    check("cmp_push", cmp_push, m_push);
    if (m_push) check("cmp_data", cmp_data, m_data);
    check("done_id_valid", done_id_valid, m_q.size() > 0);
    check("done_id", done_id, (m_q.size() > 0) ? m_q[0] : 0);
    check("busy", busy, m_in_pkt || (m_q.size() > 0));
    check("err", err, m_err);
    if (cmp_push === 1'b1) push_cycles.push_back(cyc_n);
  endtask

  // Per-requester packet sources: words remaining and the word currently presented.
  int            rem[NR];
  logic [DW-1:0] cur[NR];
  bit            have[NR];
  bit            stall_en = 1'b0;
  bit            refill1  = 1'b0;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (rem[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic present();
    for (int i = 0; i < NR; i++) begin
      if (rem[i] > 0) begin
        if (!have[i]) begin
          cur[i]  = rand_word();
          have[i] = 1'b1;
        end
        req_valid[i]          = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        req_data[i*DW +: DW]  = cur[i];
        req_last[i]           = (rem[i] == 1);
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'($urandom_range(0, 1));
        req_data[i*DW +: DW]  = rand_word();
      end
    end
  endtask

  task automatic cyc(input bit cr, input bit dn);
    present();
    cmp_credit = cr;
    cmp_done   = dn;
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    if (reset) begin
      for (int i = 0; i < NR; i++) begin rem[i] = 0; have[i] = 0; end
    end else if (m_acc >= 0) begin
      rem[m_acc]--;
      have[m_acc] = 0;
      if (refill1 && rem[m_acc] == 0) rem[m_acc] = 1;
    end
    compare();
  endtask

  task automatic cyc_auto(input bit give_cr, input bit give_dn);
    cyc(give_cr && (m_credits < CR), give_dn && (m_q.size() > 0));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((pending() || m_in_pkt || m_credits < CR || m_q.size() > 0) && n < 400) begin
      cyc_auto(1, 1);
      n++;
    end
    check({name, " drain"}, n < 400, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0);
    cyc(0, 0);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    bit cr;
    bit dn;
    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    cmp_credit = 1'b0; cmp_done = 1'b0;
    for (int i = 0; i < NR; i++) begin rem[i] = 0; have[i] = 0; end
    @(negedge clk);
    do_reset();
    check("reset cmp_data", cmp_data, 0);
    check("reset req_ready", req_ready, 0);
    check("reset err", err, 0);

    // Requester 0, 3-word packet, no credits returned.
    push_cycles.delete();
    rem[0] = 3;
    n = 0;
    while ((rem[0] > 0 || m_in_pkt) && n < 20) begin cyc(0, 0); n++; end
    cyc(0, 0);
    check("t1 bound", n < 20, 1);
    check("t1 push count", push_cycles.size(), 3);
    check("t1 consecutive", push_cycles[2] - push_cycles[0], 2);
    check("t1 model credits", m_credits, 5);
    check("t1 done_id_valid", done_id_valid, 1);
    check("t1 done_id", done_id, 0);
    drain("t1");

    // All requesters continuously valid with 1-word packets.
    do_reset();
    grant_log.delete();
    push_cycles.delete();
    refill1 = 1'b1;
    for (int i = 0; i < NR; i++) rem[i] = 1;
    n = 0;
    while (grant_log.size() < 5 && n < 60) begin cyc_auto(1, 1); n++; end
    refill1 = 1'b0;
    check("t2 bound", n < 60, 1);
    check("t2 grant0", grant_log[0], 0);
    check("t2 grant1", grant_log[1], 1);
    check("t2 grant2", grant_log[2], 2);
    check("t2 grant3", grant_log[3], 3);
    check("t2 grant4", grant_log[4], 0);
    for (int k = 0; k < 3; k++)
      check("t2 bubble", push_cycles[k+1] - push_cycles[k], 2);
    drain("t2");

    // Credit exhaustion: requester 1, 10 words, no credits returned.
    rem[1] = 10;
    for (int k = 0; k < 15; k++) cyc(0, 0);
    check("t3 accepted 8", rem[1], 2);
    check("t3 model credits", m_credits, 0);
    check("t3 stalled", req_ready, 0);
    cyc(1, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0);
    check("t3 one more", rem[1], 1);
    drain("t3");

    // Accept and credit return together at one credit.
    rem[2] = 12;
    n = 0;
    while (m_credits != 1 && n < 30) begin cyc(0, 0); n++; end
    check("t4 bound", n < 30, 1);
    for (int k = 0; k < 4; k++) begin
      r = rem[2];
      cyc(1, 0);
      check("t4 credits", m_credits, 1);
      check("t4 accepted", rem[2], r - 1);
      check("t4 ready", req_ready, 4'b0100);
    end
    drain("t4");

    // ID queue full blocks a fifth grant until a done pops it.
    do_reset();
    for (int i = 0; i < NR; i++) rem[i] = 1;
    n = 0;
    while ((pending() || m_in_pkt) && n < 40) begin cyc_auto(1, 0); n++; end
    check("t5 bound", n < 40, 1);
    rem[0] = 1;
    for (int k = 0; k < 5; k++) cyc_auto(1, 0);
    check("t5 model queue", m_q.size(), 4);
    check("t5 no grant", req_ready, 0);
    check("t5 pending", rem[0], 1);
    check("t5 busy", busy, 1);
    check("t5 head", done_id, 0);
    cyc(0, 1);
    check("t5 head advanced", done_id, 1);
    cyc(0, 0);
    check("t5 granted", req_ready, 4'b0001);
    drain("t5");

    // Sticky error sources and reset mid-packet.
    cyc(0, 1);
    check("t6 err done-empty", err, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0);
    check("t6 err sticky", err, 1);
    do_reset();
    check("t6 err cleared", err, 0);
    cyc(1, 0);
    check("t6 err credit-full", err, 1);
    do_reset();
    rem[2] = 5;
    for (int k = 0; k < 4; k++) cyc_auto(1, 0);
    reset = 1'b1;
    cyc(0, 0);
    reset = 1'b0;
    check("t6 rst cmp_push", cmp_push, 0);
    check("t6 rst cmp_data", cmp_data, 0);
    check("t6 rst req_ready", req_ready, 0);
    check("t6 rst busy", busy, 0);
    check("t6 rst done_id_valid", done_id_valid, 0);
    check("t6 rst err", err, 0);
    rem[0] = 1;
    rem[1] = 1;
    cyc(0, 0);
    check("t6 req0 wins", req_ready, 4'b0001);
    drain("t6");

    // Randomized traffic, stalls, occasional protocol errors and resets.
    stall_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NR; i++)
        if (rem[i] == 0 && $urandom_range(0, 7) == 0) rem[i] = int'($urandom_range(1, 6));
      cr = (m_credits < CR) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 199) == 0);
      dn = (m_q.size() > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      reset = ($urandom_range(0, 499) == 0);
      cyc(cr, dn);
      reset = 1'b0;
    end
    stall_en = 1'b0;
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/compressor_input_arbiter.md
# compressor_input_arbiter

Shares the single Compressor datapath (256-bit words, `push_infifo` write strobe) among `NUM_REQ` upstream streams. Packets are granted whole (no interleaving inside the compressor's history), using round-robin arbitration and credit-based flow control against the compressor input FIFO. The granted requester ID is queued in order, so the output side can route each finished compressed packet back to its owner.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 256: word width; equals Compressor `data_in` width.
- `CREDITS`, 8: compressor input FIFO depth in words.
- `ID_DEPTH`, 4: in-flight packet ID queue depth (power of 2).
- `clk` in 1: the one clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester word valid.
- `req_data` in NUM_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last` in NUM_REQ: word is the last of its packet.
- `req_ready` out NUM_REQ: word accepted when valid & ready.
- `cmp_data` out DATA_W: to Compressor `data_in`.
- `cmp_push` out 1: to Compressor `push_infifo`.
- `cmp_credit` in 1: compressor popped one input word.
- `cmp_done` in 1: compressor emitted the final output word of a packet.
- `done_id` out clog2(NUM_REQ): owner of the oldest in-flight packet.
- `done_id_valid` out 1: ID queue non-empty.
- `busy` out 1: state STREAM or ID queue non-empty.
- `err` out 1: sticky protocol error.

## Operation
- FSM states: IDLE, STREAM.
- **IDLE:** `req_ready` = 0. If any `req_valid` and ID queue not full, pick the winner: first valid requester scanning from `last_grant+1` upward with wrap. Then register `grant`, push `grant` into the ID queue, set `last_grant` = `grant`, and go to STREAM.
- **STREAM:** `req_ready[grant]` = (credits > 0); all other bits are 0.
  - On an accepted word: credits decrement, and `cmp_data`/`cmp_push` are registered from that word.
  - An accepted word with `req_last` returns the FSM to IDLE.
- Credit counter:
  - Range 0..CREDITS, reset value CREDITS.
  - +1 on `cmp_credit`, −1 on accept; both in the same cycle leaves it unchanged.
  - `cmp_credit` while at CREDITS is ignored and sets `err`.
- ID queue:
  - Push on grant; pop on `cmp_done`.
  - Push and pop in the same cycle are both honoured; the full check uses the pre-pop count.
  - `cmp_done` while empty is ignored and sets `err`.
- Non-granted requesters' `req_valid` may drop without penalty. The granted requester may stall with `req_valid` = 0 mid-packet; the FSM waits in STREAM indefinitely.
- **Reset values:**
  - Outputs: all 0 (including `cmp_data`, `err`).
  - State: IDLE, `last_grant` = NUM_REQ−1 (so requester 0 wins first), credits = CREDITS, ID queue empty.
- **Reset mid-packet:** the partial packet is discarded. The Compressor shares the same `reset` net and is cleared together with this block.

## Timing
- Arbitration: `req_valid` seen in IDLE at edge N → STREAM from N+1 → first `req_ready` during cycle N+1.
- Pass-through latency: word accepted at edge M → `cmp_push` = 1 with that data during cycle M+1, for exactly one cycle per word.
- Throughput: 1 word/cycle within a packet while credits > 0. There is exactly one idle (IDLE) cycle between packets.
- `req_ready` is combinational from registered state and credits only, never from `req_valid`.
- `done_id`/`done_id_valid` come from registered queue state; a pop at edge K updates them at K+1.

## Structure
- Package `compressor_pkg`:
  - `DATA_W` = 256.
  - Default `NUM_REQ`.
  - ID width constant.
  - FSM state enum {IDLE, STREAM}.
- Sub-module `id_fifo`: synchronous FIFO, width clog2(NUM_REQ), depth `ID_DEPTH`, with push/pop/full/empty. It is reusable for the output-routing side.
- Round-robin pick is a function inside the arbiter.

## Test plan
- Reset, then requester 0 sends a 3-word packet (last on word 3) → `cmp_push` on 3 consecutive cycles starting the cycle after the first accept, data order preserved, `done_id_valid` = 1 with `done_id` = 0; credits end at 5.
- All 4 requesters hold 1-word packets valid continuously → grant order 0,1,2,3,0, with exactly one bubble cycle between pushes.
- Requester 1 sends 10 words with `cmp_credit` held 0 → stalls after 8 accepts (`req_ready` = 0). One `cmp_credit` pulse → exactly one more word accepted.
- Accept and `cmp_credit` in the same cycle with credits = 1 → credits stay 1 and streaming continues uninterrupted.
- 4 packets granted with no `cmp_done` → the 5th requester stays un-granted (ID queue full). A `cmp_done` pulse → `done_id` advances and the grant happens the next IDLE cycle.
- `cmp_done` with the queue empty, or `cmp_credit` at 8 credits → `err` = 1 and stays 1 until `reset`. `reset` asserted mid-packet → all outputs 0 the next cycle, and requester 0 wins next.
